fifo_symbol_unpacker: RTL and testbench



---
 rtl/fifo_symbol_unpacker.sv | 135 +++++++++++++
 tb/tb_fifo_symbol_unpacker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_symbol_unpacker.sv
// Read-side master for a symbol FIFO: pulls one symbol at a time and packs
// SYMS symbols into a word offered on a valid/ready handshake, with flush.
module fifo_symbol_unpacker #(
   parameter  int SYM_W = 2,
   parameter  int SYMS  = 4,
   localparam int OUT_W = SYM_W * SYMS,
   localparam int CNT_W = $clog2(SYMS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   input  logic [SYM_W-1:0] fifo_dout,
   output logic             fifo_rd_en,
   input  logic             flush,
   output logic [OUT_W-1:0] out_data,
   output logic [CNT_W-1:0] out_syms,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      CAPTURE,
      OUT
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OUT_W-1:0] shift_q, shift_d;
   logic             rd_en_q, rd_en_d;
   logic             valid_q, valid_d;
   logic [OUT_W-1:0] data_q, data_d;
   logic [CNT_W-1:0] syms_q, syms_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             cnt_full;

   assign cnt_inc  = cnt_q + CNT_W'(1);
   assign cnt_full = (cnt_inc == CNT_W'(SYMS));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         rd_en_q <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         syms_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         rd_en_q <= rd_en_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         syms_q  <= syms_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               state_d = READ;
            end else if (flush && (cnt_q != '0)) begin
               state_d = OUT;
            end
         end
         READ:    state_d = CAPTURE;
         CAPTURE: state_d = cnt_full ? OUT : IDLE;
         OUT: begin
            if (valid_q && out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      rd_en_d = 1'b0;
      valid_d = valid_q;
      data_d  = data_q;
      syms_d  = syms_q;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               rd_en_d = 1'b1;
            end else if (flush && (cnt_q != '0)) begin
               // unfilled upper slots are already zero since the shifter clears on accept
               valid_d = 1'b1;
               data_d  = shift_q;
               syms_d  = cnt_q;
            end
         end
         CAPTURE: begin
            for (int unsigned i = 0; i < SYMS; i++) begin
               if (cnt_q == CNT_W'(i)) begin
                  shift_d[i*SYM_W +: SYM_W] = fifo_dout;
               end
            end
            cnt_d = cnt_inc;
            if (cnt_full) begin
               valid_d = 1'b1;
               data_d  = shift_d;
               syms_d  = CNT_W'(SYMS);
            end
         end
         OUT: begin
            if (valid_q && out_ready) begin
               valid_d = 1'b0;
               cnt_d   = '0;
               shift_d = '0;
            end
         end
         default: ;
      endcase
      busy_d = (state_d != IDLE) || (cnt_d != '0);
   end

   assign fifo_rd_en = rd_en_q;
   assign out_valid  = valid_q;
   assign out_data   = data_q;
   assign out_syms   = syms_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_fifo_symbol_unpacker.sv
// Bench for fifo_symbol_unpacker: behavioural FIFO with registered read data,
// scoreboard of expected words, and handshake/read-strobe protocol checks.
module tb_fifo_symbol_unpacker;

   localparam int SYM_W = 2;
   localparam int SYMS  = 4;
   localparam int OUT_W = SYM_W * SYMS;
   localparam int CNT_W = $clog2(SYMS + 1);

   typedef struct {
      logic [OUT_W-1:0] data;
      logic [CNT_W-1:0] syms;
   } word_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             fifo_empty = 1'b1;
   logic [SYM_W-1:0] fifo_dout = '0;
   logic             fifo_rd_en;
   logic             flush = 1'b0;
   logic [OUT_W-1:0] out_data;
   logic [CNT_W-1:0] out_syms;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic             busy;

   logic [SYM_W-1:0] fq[$];
   word_t            sb[$];
   int               vec_cnt = 0;
   int               err_cnt = 0;
   int               cyc = 0;
   int               rd_pulses = 0;
   logic             prev_rd = 1'b0;

   fifo_symbol_unpacker #(.SYM_W(SYM_W), .SYMS(SYMS)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd_en (fifo_rd_en),
      .flush      (flush),
      .out_data   (out_data),
      .out_syms   (out_syms),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO with registered output: data appears the cycle after the strobe
   always @(posedge clk) begin
      if (rst) begin
         fifo_dout <= '0;
      end else if (fifo_rd_en && fq.size() > 0) begin
         fifo_dout <= fq.pop_front();
      end
   end

   always begin
      @(negedge clk);
      #1;
      fifo_empty = (fq.size() == 0);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Monitor: samples after inputs settle, before the next rising edge
   always begin
      @(negedge clk);
      #2;
      if (!rst) begin
         check("rd_adjacent", 32'(prev_rd && fifo_rd_en), 32'd0);
         check("rd_while_out", 32'(fifo_rd_en && out_valid), 32'd0);
         if (fifo_rd_en) rd_pulses++;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
               word_t w;
               w = sb.pop_front();
               check("word_data", 32'(out_data), 32'(w.data));
               check("word_syms", 32'(out_syms), 32'(w.syms));
            end
         end
      end
      prev_rd = fifo_rd_en;
   end

   task automatic wait_rd(output int t);
      t = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (fifo_rd_en) begin
            t = cyc;
            return;
         end
      end
      check("timeout_rd_en", 32'd0, 32'd1);
   endtask

   task automatic wait_valid(output int t);
      t = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid) begin
            t = cyc;
            return;
         end
      end
      check("timeout_out_valid", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic push_word(input logic [OUT_W-1:0] d, input logic [CNT_W-1:0] s);
      word_t w;
      w.data = d;
      w.syms = s;
      sb.push_back(w);
   endtask

   initial begin
      int t0, t1;
      idle(3);
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_syms", 32'(out_syms), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;

      // reset while the read strobe is high
      fq.push_back(2'b11);
      wait_rd(t0);
      rst = 1'b1;
      @(negedge clk);
      check("midrd_rd_en", 32'(fifo_rd_en), 32'd0);
      check("midrd_valid", 32'(out_valid), 32'd0);
      check("midrd_busy", 32'(busy), 32'd0);
      fq.delete();
      rst = 1'b0;
      idle(3);

      // full word, timing and pulse width
      rd_pulses = 0;
      fq.push_back(2'b01); fq.push_back(2'b10); fq.push_back(2'b11); fq.push_back(2'b00);
      push_word(8'b00_11_10_01, CNT_W'(4));
      wait_rd(t0);
      wait_valid(t1);
      check("full_latency", 32'(t1 - t0), 32'd11);
      check("full_data", 32'(out_data), 32'h39);
      @(negedge clk);
      check("full_pulse", 32'(out_valid), 32'd0);
      check("full_rd_count", 32'(rd_pulses), 32'd4);
      check("full_busy", 32'(busy), 32'd0);

      // backpressure with FIFO still holding data, then a 2-symbol flush
      out_ready = 1'b0;
      fq.push_back(2'b01); fq.push_back(2'b10); fq.push_back(2'b11); fq.push_back(2'b00);
      fq.push_back(2'b11); fq.push_back(2'b01);
      push_word(8'h39, CNT_W'(4));
      wait_valid(t1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_data", 32'(out_data), 32'h39);
         check("stall_syms", 32'(out_syms), 32'd4);
         check("stall_no_rd", 32'(fifo_rd_en), 32'd0);
      end
      out_ready = 1'b1;
      idle(10);
      check("partial_busy", 32'(busy), 32'd1);
      check("partial_no_word", 32'(out_valid), 32'd0);
      push_word(8'h07, CNT_W'(2));
      flush = 1'b1;
      wait_valid(t1);
      flush = 1'b0;
      check("flush_data", 32'(out_data), 32'h07);
      idle(2);
      check("flush_busy", 32'(busy), 32'd0);

      // flush with nothing buffered produces nothing
      flush = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("empty_flush_valid", 32'(out_valid), 32'd0);
         check("empty_flush_rd", 32'(fifo_rd_en), 32'd0);
      end
      flush = 1'b0;

      // read wins over flush in the same IDLE cycle
      fq.push_back(2'b10);
      idle(8);
      check("one_sym_busy", 32'(busy), 32'd1);
      fq.push_back(2'b01);
      flush = 1'b1;
      @(negedge clk);
      check("prio_rd_en", 32'(fifo_rd_en), 32'd1);
      check("prio_valid", 32'(out_valid), 32'd0);
      flush = 1'b0;
      idle(6);
      check("prio_no_word", 32'(out_valid), 32'd0);
      push_word(8'h06, CNT_W'(2));
      flush = 1'b1;
      wait_valid(t1);
      flush = 1'b0;
      check("prio_syms", 32'(out_syms), 32'd2);
      idle(3);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
